vfb_arbiter: RTL and testbench

Frame-buffer scheduler between the video-in write path and the video-out read path sharing one DDR3 user command port. It decides which channel issues the next fixed-size burst, generates burst addresses, and manages a triple-buffered frame store so the display always reads the newest complete camera frame. It sits in the memory-clock domain between the pixel FIFOs and the DDR3 controller command interface.

---
 rtl/vfb_pkg.sv | 23 ++
 rtl/vfb_chan_addr.sv | 60 ++++++
 rtl/vfb_arbiter.sv | 169 ++++++++++++++++
 tb/tb_vfb_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vfb_pkg.sv
// rtl/vfb_pkg.sv - shared types and bank-rotation helper for the frame-buffer scheduler
package vfb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef logic [1:0] bank_t;

  // Pick the write bank that collides with neither the display bank nor the newest complete frame.
  function automatic bank_t next_wr_bank(input bank_t rd, input bank_t latest);
    bank_t res;
    if (rd == latest) begin
      res = (latest == 2'd2) ? 2'd0 : latest + 2'd1;
    end else begin
      res = 2'd3 - rd - latest;
    end
    return res;
  endfunction

endpackage

// File: rtl/vfb_chan_addr.sv
// rtl/vfb_chan_addr.sv - per-channel frame progress: active flag, burst offset, frame-complete
module vfb_chan_addr
  import vfb_pkg::*;
#(
  parameter int          ADDR_WIDTH = 29,
  parameter int unsigned FRAME_SIZE = 32'h0020_0000,
  parameter int unsigned BURST_INC  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start_i,
  input  logic                  advance_i,
  output logic                  active_o,
  output logic [ADDR_WIDTH-1:0] offset_o,
  output logic                  complete_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_OFF = ADDR_WIDTH'(FRAME_SIZE - BURST_INC);
  localparam logic [ADDR_WIDTH-1:0] INC      = ADDR_WIDTH'(BURST_INC);

  logic                  active_q, active_d;
  logic                  complete_q, complete_d;
  logic [ADDR_WIDTH-1:0] offset_q, offset_d;

  // A new frame overrides any same-cycle advance so the restart always begins at offset 0.
  always_comb begin
    active_d   = active_q;
    complete_d = complete_q;
    offset_d   = offset_q;
    if (frame_start_i) begin
      active_d   = 1'b1;
      complete_d = 1'b0;
      offset_d   = '0;
    end else if (advance_i && active_q) begin
      if (offset_q == LAST_OFF) begin
        active_d   = 1'b0;
        complete_d = 1'b1;
      end else begin
        offset_d = offset_q + INC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q   <= 1'b0;
      complete_q <= 1'b0;
      offset_q   <= '0;
    end else begin
      active_q   <= active_d;
      complete_q <= complete_d;
      offset_q   <= offset_d;
    end
  end

  assign active_o   = active_q;
  assign offset_o   = offset_q;
  assign complete_o = complete_q;

endmodule

// File: rtl/vfb_arbiter.sv
// rtl/vfb_arbiter.sv - DDR burst scheduler and triple-buffer bank manager for video in/out
module vfb_arbiter
  import vfb_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 29,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FRAME_SIZE  = 32'h0020_0000,
  parameter int unsigned BURST_INC   = 64,
  parameter int unsigned BURST_WORDS = 16,
  parameter int          LEVEL_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   calib_done,
  input  logic                   wr_frame_start,
  input  logic [LEVEL_WIDTH-1:0] wr_fifo_level,
  input  logic                   rd_frame_start,
  input  logic [LEVEL_WIDTH-1:0] rd_fifo_space,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic                   cmd_write,
  output logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic                   burst_done,
  output logic [1:0]             wr_bank,
  output logic [1:0]             rd_bank,
  output logic [7:0]             frame_drop
);

  state_t                state_q, state_d;
  logic                  cmd_write_q, cmd_write_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic                  last_write_q, last_write_d;
  logic                  stale_q, stale_d;
  bank_t                 wr_bank_q, wr_bank_d;
  bank_t                 rd_bank_q, rd_bank_d;
  bank_t                 latest_q, latest_d;
  logic [7:0]            frame_drop_q, frame_drop_d;

  logic                  wr_active, wr_complete, rd_active, rd_complete;
  logic [ADDR_WIDTH-1:0] wr_offset, rd_offset;
  logic                  wr_elig, rd_elig, take, pick_write, done_ok;

  function automatic logic [ADDR_WIDTH-1:0] bank_base(input bank_t b);
    return ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(b) * ADDR_WIDTH'(FRAME_SIZE);
  endfunction

  assign wr_elig = wr_active && (wr_fifo_level >= LEVEL_WIDTH'(BURST_WORDS));
  assign rd_elig = rd_active && (rd_fifo_space >= LEVEL_WIDTH'(BURST_WORDS));

  // A burst completing after its channel restarted belongs to the old frame and must not advance.
  assign done_ok = (state_q == ST_WAIT) && burst_done && !stale_q;

  vfb_chan_addr #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .FRAME_SIZE(FRAME_SIZE),
    .BURST_INC (BURST_INC)
  ) u_wr_chan (
    .clk          (clk),
    .rst          (rst),
    .frame_start_i(wr_frame_start),
    .advance_i    (done_ok && cmd_write_q),
    .active_o     (wr_active),
    .offset_o     (wr_offset),
    .complete_o   (wr_complete)
  );

  vfb_chan_addr #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .FRAME_SIZE(FRAME_SIZE),
    .BURST_INC (BURST_INC)
  ) u_rd_chan (
    .clk          (clk),
    .rst          (rst),
    .frame_start_i(rd_frame_start),
    .advance_i    (done_ok && !cmd_write_q),
    .active_o     (rd_active),
    .offset_o     (rd_offset),
    .complete_o   (rd_complete)
  );

  always_comb begin
    state_d      = state_q;
    cmd_write_d  = cmd_write_q;
    cmd_addr_d   = cmd_addr_q;
    last_write_d = last_write_q;
    stale_d      = stale_q;
    take         = 1'b0;
    pick_write   = 1'b0;
    cmd_valid    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (calib_done && (wr_elig || rd_elig)) begin
          take       = 1'b1;
          pick_write = wr_elig && (!rd_elig || !last_write_q);
          state_d    = ST_CMD;
        end
      end
      ST_CMD: begin
        cmd_valid = 1'b1;
        if (cmd_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (burst_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (take) begin
      cmd_write_d  = pick_write;
      last_write_d = pick_write;
      cmd_addr_d   = pick_write ? bank_base(wr_bank_q) + wr_offset
                                : bank_base(rd_bank_q) + rd_offset;
      stale_d      = pick_write ? wr_frame_start : rd_frame_start;
    end else if (state_q != ST_IDLE && (cmd_write_q ? wr_frame_start : rd_frame_start)) begin
      stale_d = 1'b1;
    end
  end

  // Write completion is resolved first so a same-cycle read start picks up the fresh frame.
  always_comb begin
    latest_d     = latest_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    frame_drop_d = frame_drop_q;
    if (wr_frame_start) begin
      if (wr_complete) begin
        latest_d = wr_bank_q;
      end else if (wr_active && frame_drop_q != 8'hFF) begin
        frame_drop_d = frame_drop_q + 8'd1;
      end
    end
    if (rd_frame_start) rd_bank_d = latest_d;
    if (wr_frame_start) wr_bank_d = next_wr_bank(rd_bank_d, latest_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cmd_write_q  <= 1'b0;
      cmd_addr_q   <= '0;
      last_write_q <= 1'b1;
      stale_q      <= 1'b0;
      wr_bank_q    <= 2'd0;
      rd_bank_q    <= 2'd2;
      latest_q     <= 2'd2;
      frame_drop_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      cmd_write_q  <= cmd_write_d;
      cmd_addr_q   <= cmd_addr_d;
      last_write_q <= last_write_d;
      stale_q      <= stale_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      latest_q     <= latest_d;
      frame_drop_q <= frame_drop_d;
    end
  end

  // The read side's completion flag has no bank-rotation role; only the write frame gates latest.
  logic unused_rd_complete;
  assign unused_rd_complete = rd_complete;

  assign cmd_write  = cmd_write_q;
  assign cmd_addr   = cmd_addr_q;
  assign wr_bank    = wr_bank_q;
  assign rd_bank    = rd_bank_q;
  assign frame_drop = frame_drop_q;

endmodule

// File: tb/tb_vfb_arbiter.sv
// tb/tb_vfb_arbiter.sv - directed vector bench for the frame-buffer scheduler
module tb_vfb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        calib_done = 1'b0;
  logic        wr_frame_start = 1'b0;
  logic [9:0]  wr_fifo_level = '0;
  logic        rd_frame_start = 1'b0;
  logic [9:0]  rd_fifo_space = '0;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic        cmd_write;
  logic [28:0] cmd_addr;
  logic        burst_done = 1'b0;
  logic [1:0]  wr_bank;
  logic [1:0]  rd_bank;
  logic [7:0]  frame_drop;

  int n_total = 0;
  int n_pass  = 0;

  // Small frame (8 bursts) keeps full-frame sequences short; banks sit at 0x1000/0x1200/0x1400.
  vfb_arbiter #(
    .ADDR_WIDTH (29),
    .BASE_ADDR  (32'h1000),
    .FRAME_SIZE (32'h200),
    .BURST_INC  (64),
    .BURST_WORDS(16),
    .LEVEL_WIDTH(10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .calib_done    (calib_done),
    .wr_frame_start(wr_frame_start),
    .wr_fifo_level (wr_fifo_level),
    .rd_frame_start(rd_frame_start),
    .rd_fifo_space (rd_fifo_space),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .burst_done    (burst_done),
    .wr_bank       (wr_bank),
    .rd_bank       (rd_bank),
    .frame_drop    (frame_drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  wr_lvl;
    logic [9:0]  rd_sp;
    logic        exp_write;
    logic [28:0] exp_addr;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic wait_valid(input string nm, output bit ok);
    int n = 0;
    while (!cmd_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = cmd_valid;
    if (!ok) begin
      n_total++;
      $display("FAIL %s: cmd_valid timeout got 0 expected 1", nm);
    end
  endtask

  task automatic burst(input logic ew, input logic [28:0] ea, input string nm);
    bit ok;
    wait_valid(nm, ok);
    if (ok) begin
      chk({nm, " write"}, cmd_write, ew);
      chk({nm, " addr"}, cmd_addr, ea);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      @(negedge clk);
      burst_done = 1'b1;
      @(negedge clk);
      burst_done = 1'b0;
    end
  endtask

  task automatic pulse(input logic w, input logic r);
    wr_frame_start = w;
    rd_frame_start = r;
    @(negedge clk);
    wr_frame_start = 1'b0;
    rd_frame_start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int cnt;

    vecs[0]  = '{10'd16,  10'd16,  1'b0, 29'h1400};
    vecs[1]  = '{10'd16,  10'd16,  1'b1, 29'h1000};
    vecs[2]  = '{10'd16,  10'd16,  1'b0, 29'h1440};
    vecs[3]  = '{10'd16,  10'd16,  1'b1, 29'h1040};
    vecs[4]  = '{10'd16,  10'd16,  1'b0, 29'h1480};
    vecs[5]  = '{10'd16,  10'd16,  1'b1, 29'h1080};
    vecs[6]  = '{10'd100, 10'd0,   1'b1, 29'h10C0};
    vecs[7]  = '{10'd100, 10'd15,  1'b1, 29'h1100};
    vecs[8]  = '{10'd5,   10'd500, 1'b0, 29'h14C0};
    vecs[9]  = '{10'd16,  10'd15,  1'b1, 29'h1140};
    vecs[10] = '{10'd16,  10'd0,   1'b1, 29'h1180};
    vecs[11] = '{10'd16,  10'd0,   1'b1, 29'h11C0};
    vecs[12] = '{10'd16,  10'd16,  1'b0, 29'h1500};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset cmd_valid", cmd_valid, 0);
    chk("reset cmd_write", cmd_write, 0);
    chk("reset cmd_addr", cmd_addr, 0);
    chk("reset wr_bank", wr_bank, 0);
    chk("reset rd_bank", rd_bank, 2);
    chk("reset frame_drop", frame_drop, 0);

    calib_done = 1'b1;
    pulse(1'b1, 1'b1);
    chk("first start wr_bank", wr_bank, 0);
    chk("first start rd_bank", rd_bank, 2);
    chk("first start drop", frame_drop, 0);

    for (int i = 0; i < 13; i++) begin
      wr_fifo_level = vecs[i].wr_lvl;
      rd_fifo_space = vecs[i].rd_sp;
      burst(vecs[i].exp_write, vecs[i].exp_addr, $sformatf("vec%0d", i));
    end

    wr_fifo_level = 10'd16;
    rd_fifo_space = 10'd0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cmd_valid) cnt++;
    end
    chk("finished frame not granted", cnt, 0);

    // Completed write frame rotates into latest; display then picks it up.
    wr_fifo_level = 10'd0;
    pulse(1'b1, 1'b0);
    chk("rotate wr_bank", wr_bank, 1);
    chk("rotate rd_bank", rd_bank, 2);
    chk("rotate drop", frame_drop, 0);
    pulse(1'b0, 1'b1);
    chk("display rd_bank", rd_bank, 0);

    wr_fifo_level = 10'd16;
    for (int k = 0; k < 4; k++) burst(1'b1, 29'h1200 + 29'(k * 64), $sformatf("half%0d", k));
    wr_fifo_level = 10'd0;
    pulse(1'b1, 1'b0);
    chk("drop count", frame_drop, 1);
    chk("drop wr_bank", wr_bank, 1);
    wr_fifo_level = 10'd16;
    burst(1'b1, 29'h1200, "drop restart");

    for (int k = 1; k < 8; k++) burst(1'b1, 29'h1200 + 29'(k * 64), $sformatf("full%0d", k));
    wr_fifo_level = 10'd0;
    pulse(1'b1, 1'b1);
    chk("simul rd_bank", rd_bank, 1);
    chk("simul wr_bank", wr_bank, 2);
    chk("simul drop", frame_drop, 1);

    wr_fifo_level = 10'd16;
    wait_valid("stall", ok);
    if (ok) begin
      chk("stall write", cmd_write, 1);
      chk("stall addr", cmd_addr, 32'h1400);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (cmd_valid && cmd_write && cmd_addr == 29'h1400) cnt++;
      end
      chk("stall hold cycles", cnt, 10);
      cmd_ready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (cmd_valid) cnt++;
      end
      chk("single accept", cnt, 0);
      cmd_ready = 1'b0;
      burst_done = 1'b1;
      @(negedge clk);
      burst_done = 1'b0;
    end
    burst(1'b1, 29'h1440, "after stall");

    // Restart the write frame while its burst is outstanding.
    wait_valid("stale", ok);
    if (ok) begin
      chk("stale addr", cmd_addr, 32'h1480);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      wr_frame_start = 1'b1;
      @(negedge clk);
      wr_frame_start = 1'b0;
      burst_done = 1'b1;
      @(negedge clk);
      burst_done = 1'b0;
      chk("stale drop", frame_drop, 2);
      chk("stale wr_bank", wr_bank, 2);
    end
    burst(1'b1, 29'h1400, "stale restart");

    calib_done = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cmd_valid) cnt++;
    end
    chk("calib low no cmd", cnt, 0);
    calib_done = 1'b1;
    @(negedge clk);
    chk("calib rise latency", cmd_valid, 1);
    chk("calib rise addr", cmd_addr, 32'h1440);

    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("wait-reset cmd_valid", cmd_valid, 0);
    chk("wait-reset cmd_write", cmd_write, 0);
    chk("wait-reset cmd_addr", cmd_addr, 0);
    chk("wait-reset wr_bank", wr_bank, 0);
    chk("wait-reset rd_bank", rd_bank, 2);
    chk("wait-reset frame_drop", frame_drop, 0);
    burst_done = 1'b1;
    rd_fifo_space = 10'd16;
    @(negedge clk);
    burst_done = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cmd_valid) cnt++;
    end
    chk("late done no cmd", cnt, 0);
    pulse(1'b1, 1'b0);
    chk("post-reset wr_bank", wr_bank, 0);
    burst(1'b1, 29'h1000, "post-reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
